// File: rtl/sram_bus_responder_if.sv
// CPU data-port SRAM-style bus: request fields from the CPU, registered read data back.
interface sram_bus_responder_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  // No handshake: en=1 is an accepted access that same edge; we==0 is a read whose
  // data appears after that edge and is held until the next read.
  modport master (output sram_en, sram_we, sram_addr, sram_wdata, input sram_rdata);
  modport slave  (input sram_en, sram_we, sram_addr, sram_wdata, output sram_rdata);
endinterface

// File: rtl/sram_bus_responder.sv
// Data-port responder: word-addressed data RAM plus a small peripheral register file
// (LED, switches, timer with compare IRQ, display value, scratch).
module sram_bus_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
  parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_bus_responder_if.slave   bus,
  input  logic [7:0]            switch_in,
  output logic [15:0]           led,
  output logic [31:0]           num_data,
  output logic                  timer_irq
);

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_TIMER   = 16'hF010;
  localparam logic [15:0] OFF_CMP     = 16'hF014;
  localparam logic [15:0] OFF_IRQ_CLR = 16'hF018;
  localparam logic [15:0] OFF_NUM     = 16'hF020;
  localparam logic [15:0] OFF_SCRATCH = 16'hF030;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  we);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = we[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] r_ram [2**RAM_AW];
  logic [31:0] r_ram_q;
  logic [31:0] r_periph_q;
  logic        r_rd_sel_ram;
  logic [15:0] r_led;
  logic [31:0] r_timer;
  logic [31:0] r_cmp;
  logic [31:0] r_num;
  logic [31:0] r_scratch;
  logic        r_irq;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;

  logic              w_hit_periph;
  logic              w_rd;
  logic              w_wr;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_idx;
  logic              w_ram_wr;
  logic              w_ram_rd;
  logic              w_pwr;
  logic              w_irq_clr;
  logic [31:0]       w_prd;

  assign w_hit_periph = (bus.sram_addr & CONF_MASK) == CONF_BASE;
  assign w_rd         = bus.sram_en && (bus.sram_we == 4'b0000);
  assign w_wr         = bus.sram_en && (bus.sram_we != 4'b0000);
  assign w_off        = {bus.sram_addr[15:2], 2'b00};
  assign w_idx        = bus.sram_addr[RAM_AW+1:2];
  // Gating with resetn drops a RAM write that lands while reset is still held.
  assign w_ram_wr     = w_wr && !w_hit_periph && resetn;
  assign w_ram_rd     = w_rd && !w_hit_periph;
  assign w_pwr        = w_wr && w_hit_periph;
  assign w_irq_clr    = w_pwr && (w_off == OFF_IRQ_CLR) && bus.sram_we[0] && bus.sram_wdata[0];

  always_comb begin
    w_prd = '0;
    case (w_off)
      OFF_LED:     w_prd = {16'h0000, r_led};
      OFF_SWITCH:  w_prd = {24'h0, r_sw_sync};
      OFF_TIMER:   w_prd = r_timer;
      OFF_CMP:     w_prd = r_cmp;
      OFF_IRQ_CLR: w_prd = {31'b0, r_irq};
      OFF_NUM:     w_prd = r_num;
      OFF_SCRATCH: w_prd = r_scratch;
      default:     w_prd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sram_we[i]) r_ram[w_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      end
    end
    if (w_ram_rd) r_ram_q <= r_ram[w_idx];
  end

  // Read data is split into a RAM-side and a peripheral-side register; the select
  // flag remembers which one the last read loaded, so the output holds between reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_periph_q   <= '0;
      r_rd_sel_ram <= 1'b0;
    end else if (w_rd) begin
      r_rd_sel_ram <= !w_hit_periph;
      if (w_hit_periph) r_periph_q <= w_prd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led     <= '0;
      r_num     <= '0;
      r_scratch <= '0;
      r_cmp     <= 32'hffff_ffff;
      r_timer   <= '0;
      r_irq     <= 1'b0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switch_in;
      r_sw_sync <= r_sw_meta;
      if (w_pwr && w_off == OFF_LED)
        r_led <= byte_merge({16'h0000, r_led}, bus.sram_wdata, {2'b00, bus.sram_we[1:0]})[15:0];
      if (w_pwr && w_off == OFF_NUM)     r_num     <= byte_merge(r_num, bus.sram_wdata, bus.sram_we);
      if (w_pwr && w_off == OFF_SCRATCH) r_scratch <= byte_merge(r_scratch, bus.sram_wdata, bus.sram_we);
      if (w_pwr && w_off == OFF_CMP)     r_cmp     <= byte_merge(r_cmp, bus.sram_wdata, bus.sram_we);
      if (w_pwr && w_off == OFF_TIMER)   r_timer   <= byte_merge(r_timer, bus.sram_wdata, bus.sram_we);
      else                               r_timer   <= r_timer + 32'd1;
      // Set has priority over a clear issued in the same cycle.
      r_irq <= (r_timer == r_cmp) || (r_irq && !w_irq_clr);
    end
  end

  assign bus.sram_rdata = r_rd_sel_ram ? r_ram_q : r_periph_q;
  assign led            = r_led;
  assign num_data       = r_num;
  assign timer_irq      = r_irq;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder: RAM lanes/alias, timer, IRQ, switch sync, peripherals.
module tb_sram_bus_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_irq;
  logic [31:0] rd;
  int          n_tests = 0;
  int          n_fail = 0;

  sram_bus_responder_if bus();

  sram_bus_responder #(
    .RAM_AW(12), .CONF_BASE(32'hbfaf_0000), .CONF_MASK(32'hffff_0000)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .switch_in(switch_in),
    .led(led), .num_data(num_data), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] P = 32'hbfaf_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    bus.sram_en    = 1'b1;
    bus.sram_we    = we;
    bus.sram_addr  = addr;
    bus.sram_wdata = data;
    @(posedge clk);
    #1;
    bus.sram_en = 1'b0;
    bus.sram_we = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.sram_en   = 1'b1;
    bus.sram_we   = 4'b0000;
    bus.sram_addr = addr;
    @(posedge clk);
    #1;
    bus.sram_en = 1'b0;
    data = bus.sram_rdata;
  endtask

  initial begin
    bus.sram_en = 1'b0; bus.sram_we = 4'b0000; bus.sram_addr = '0; bus.sram_wdata = '0;
    switch_in = 8'h00;

    // Reset values
    idle(3);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num_data, 32'h0);
    check("rst_rdata", bus.sram_rdata, 32'h0);
    check("rst_irq", {31'b0, timer_irq}, 32'h0);
    resetn = 1'b1;
    bus_read(P | 32'hF010, rd);
    check("timer_first_small", {31'b0, rd <= 32'd2}, 32'h1);
    bus_read(P | 32'hF014, rd);
    check("rst_cmp", rd, 32'hffff_ffff);
    bus_read(P | 32'hF030, rd);
    check("rst_scratch", rd, 32'h0);

    // RAM byte lanes and alias
    bus_write(32'h0000_0100, 32'h1122_3344, 4'b1111);
    bus_write(32'h0000_0100, 32'hAABB_CCDD, 4'b0010);
    bus_read(32'h0000_0100, rd);
    check("ram_lane1", rd, 32'h1122_CC44);
    bus_read(32'h0001_0100, rd);
    check("ram_alias", rd, 32'h1122_CC44);
    bus_write(32'h0000_0104, 32'h0F0E_0D0C, 4'b1111);
    bus_read(32'h0000_0107, rd);
    check("ram_low_bits_ignored", rd, 32'h0F0E_0D0C);

    // Timer load and wrap: each read returns the value before its edge
    bus_write(P | 32'hF010, 32'hffff_fffe, 4'b1111);
    bus_read(P | 32'hF010, rd); check("timer_load", rd, 32'hffff_fffe);
    bus_read(P | 32'hF010, rd); check("timer_inc", rd, 32'hffff_ffff);
    bus_read(P | 32'hF010, rd); check("timer_wrap", rd, 32'h0000_0000);
    bus_read(P | 32'hF010, rd); check("timer_after_wrap", rd, 32'h0000_0001);
    check("irq_from_wrap_match", {31'b0, timer_irq}, 32'h1);

    // IRQ set / sticky / clear
    bus_write(P | 32'hF014, 32'h0000_0040, 4'b1111);
    bus_write(P | 32'hF018, 32'h0000_0001, 4'b0001);
    check("irq_cleared", {31'b0, timer_irq}, 32'h0);
    bus_read(P | 32'hF018, rd);
    check("irq_reg_read0", rd, 32'h0);
    bus_write(P | 32'hF010, 32'h0000_003e, 4'b1111);
    idle(1);
    check("irq_before_match", {31'b0, timer_irq}, 32'h0);
    idle(1);
    check("irq_on_match_cycle", {31'b0, timer_irq}, 32'h0);
    idle(1);
    check("irq_set", {31'b0, timer_irq}, 32'h1);
    idle(3);
    check("irq_sticky", {31'b0, timer_irq}, 32'h1);
    bus_read(P | 32'hF018, rd);
    check("irq_reg_read1", rd, 32'h1);
    bus_write(P | 32'hF018, 32'h0000_0000, 4'b0001);
    check("irq_clr_wdata0", {31'b0, timer_irq}, 32'h1);
    bus_write(P | 32'hF018, 32'h0000_0001, 4'b0001);
    check("irq_clr", {31'b0, timer_irq}, 32'h0);
    bus_write(P | 32'hF010, 32'h0000_003e, 4'b1111);
    idle(2);
    bus_write(P | 32'hF018, 32'h0000_0001, 4'b0001);
    check("irq_set_beats_clr", {31'b0, timer_irq}, 32'h1);
    idle(1);
    check("irq_set_beats_clr_hold", {31'b0, timer_irq}, 32'h1);

    // Switch synchroniser
    switch_in = 8'hA5;
    bus_read(P | 32'hF004, rd); check("sw_s0", rd, 32'h0);
    bus_read(P | 32'hF004, rd); check("sw_s1", rd, 32'h0);
    bus_read(P | 32'hF004, rd); check("sw_s2", rd, 32'h0000_00A5);

    // Peripheral miscellany
    bus_write(P | 32'hF000, 32'hDEAD_BEEF, 4'b1111);
    check("led_out", {16'h0, led}, 32'h0000_BEEF);
    bus_read(P | 32'hF000, rd);
    check("led_read", rd, 32'h0000_BEEF);
    idle(2);
    bus_write(P | 32'hF030, 32'h1234_5678, 4'b1111);
    check("rdata_hold", bus.sram_rdata, 32'h0000_BEEF);
    bus_read(P | 32'hF008, rd);
    check("unmapped_read", rd, 32'h0);
    bus_write(P | 32'hF030, 32'hAABB_CCDD, 4'b1001);
    bus_read(P | 32'hF030, rd);
    check("scratch_merge", rd, 32'hAA34_56DD);
    bus_write(P | 32'hF020, 32'hCAFE_F00D, 4'b1111);
    check("num_out", num_data, 32'hCAFE_F00D);
    bus_read(P | 32'hF020, rd);
    check("num_read", rd, 32'hCAFE_F00D);
    bus_write(P | 32'hF000, 32'h0000_1234, 4'b0010);
    check("led_lane1", {16'h0, led}, 32'h0000_12EF);

    // Asynchronous reset mid-run
    #2;
    resetn = 1'b0;
    #1;
    check("arst_led", {16'h0, led}, 32'h0);
    check("arst_num", num_data, 32'h0);
    check("arst_rdata", bus.sram_rdata, 32'h0);
    check("arst_irq", {31'b0, timer_irq}, 32'h0);
    idle(2);
    resetn = 1'b1;
    bus_read(P | 32'hF030, rd);
    check("arst_scratch", rd, 32'h0);
    bus_read(32'h0000_0100, rd);
    check("ram_kept_over_reset", rd, 32'h1122_CC44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
